// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump reader and its data memory.
// The CSUM state exists only when MEM_DUMP_CHECKSUM_EN is defined.
package mem_dump_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Bundles the control, memory read port and byte stream of mem_dump_reader.
// slave is the reader itself; master is the host/memory side.
interface mem_dump_reader_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;

    modport slave (
        input  start, start_addr, word_count, mem_rdata, tx_ready,
        output busy, done, mem_rd_en, mem_addr, tx_valid, tx_data
    );

    modport master (
        output start, start_addr, word_count, mem_rdata, tx_ready,
        input  busy, done, mem_rd_en, mem_addr, tx_valid, tx_data
    );

endinterface

// File: rtl/mem_dump_reader_word_serializer.sv
// Loads one word and emits it MSB byte first under valid/ready, flagging the last byte.
// 'single' turns the load into a one-byte transfer of the top byte.
module word_serializer
    import mem_dump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              single,
    input  logic [DATA_W-1:0] word,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              last
);

    localparam int BYTES = bytes_of(DATA_W);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              single_q;

    assign tx_data = shreg[DATA_W-1 -: 8];
    assign last    = single_q || (idx == IDX_W'(BYTES - 1));

    // A load wins over a same-cycle transfer so a follow-on byte can start without a gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            idx      <= '0;
            single_q <= 1'b0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= word;
            idx      <= '0;
            single_q <= single;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (last) begin
                tx_valid <= 1'b0;
            end else begin
                shreg <= shreg << 8;
                idx   <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a contiguous range of data-memory words out as big-endian bytes.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_dump_reader_if.slave     bus
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;

    logic              ser_load;
    logic              ser_single;
    logic [DATA_W-1:0] ser_word;
    logic              ser_valid;
    logic [7:0]        ser_data;
    logic              ser_last;
    logic              xfer;
    logic              final_word;

    assign xfer       = ser_valid && bus.tx_ready;
    assign final_word = (remaining == (ADDR_W+1)'(1));

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_load;

    // The checksum byte is loaded on the final data transfer, so it follows with no bubble.
    assign csum_load  = (state == S_SEND) && xfer && ser_last && final_word;
    assign ser_load   = (state == S_WAIT) || csum_load;
    assign ser_single = csum_load;
    assign ser_word   = csum_load ? {csum ^ ser_data, {(DATA_W-8){1'b0}}} : bus.mem_rdata;
`else
    assign ser_load   = (state == S_WAIT);
    assign ser_single = 1'b0;
    assign ser_word   = bus.mem_rdata;
`endif

    word_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .single   (ser_single),
        .word     (ser_word),
        .tx_ready (bus.tx_ready),
        .tx_valid (ser_valid),
        .tx_data  (ser_data),
        .last     (ser_last)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.tx_valid  = ser_valid;
    assign bus.tx_data   = ser_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q    <= bus.start_addr;
                        remaining <= bus.word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                        if (bus.word_count == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_READ;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    rd_en_q <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        csum <= csum ^ ser_data;
`endif
                        if (ser_last) begin
                            remaining <= remaining - (ADDR_W+1)'(1);
                            addr_q    <= addr_q + ADDR_W'(1);
                            if (final_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                                state  <= S_CSUM;
`else
                                state  <= S_DONE;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
`endif
                            end else begin
                                state   <= S_READ;
                                rd_en_q <= 1'b1;
                            end
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Reads a contiguous range of words out of the MIPS data memory and streams it as bytes over a valid/ready interface. It provides the read-back path for memory contents that the bench or a loader writes, so a host or checker can dump `data_mem` without hierarchical references. It sits beside `data_mem` on a dedicated synchronous read port. The CPU side of the memory is not touched.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W words (1024).
- `DATA_W`, 32: memory word width; must be a multiple of 8; `BYTES = DATA_W/8`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word index to read.
- `word_count`  in  ADDR_W+1  number of words, 0..2^ADDR_W.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse on completion.
- `mem_rd_en`  out  1  read strobe to data memory.
- `mem_addr`  out  ADDR_W  word index for the read.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_rd_en`.
- `tx_valid`  out  1  byte available.
- `tx_ready`  in  1  sink accepts the byte; a transfer occurs when `tx_valid && tx_ready`.
- `tx_data`  out  8  byte payload.

## Operation
- States: IDLE, READ, WAIT, SEND, CSUM (CSUM only with the checksum feature), DONE.
- IDLE: when `start`=1, latch `start_addr` into the address counter and `word_count` into the remaining counter.
  - If `word_count`=0, go to DONE.
  - Otherwise go to READ.
- READ: `mem_rd_en`=1 and `mem_addr`=current address for exactly one cycle. Go to WAIT.
- WAIT: capture `mem_rdata` into the shift register, set byte index to 0, go to SEND.
- SEND:
  - `tx_valid`=1 and `tx_data` = the current byte, big-endian (MSB byte first).
  - On a transfer, advance the byte index.
  - On the transfer of byte `BYTES-1`: decrement remaining and increment address modulo 2^ADDR_W (wraps 1023→0).
  - After that last byte: go to READ if remaining>0, otherwise go to CSUM (feature on) or DONE.
- DONE: `done`=1 for one cycle, `busy`=0, go to IDLE.
- `start` while not in IDLE is ignored. A new `start` is accepted in the cycle after DONE.
- `tx_data` and `tx_valid` hold stable while `tx_valid && !tx_ready`. `tx_valid` never drops without a transfer.
- `word_count` > 2^ADDR_W cannot occur: the field is ADDR_W+1 bits, so its maximum is exactly a full memory pass.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `tx_valid`=0, `tx_data`=0, state IDLE, all counters 0.
- `start` at cycle 0 gives:
  - cycle 1: READ, `mem_rd_en`=1.
  - cycle 2: WAIT.
  - cycle 3: first `tx_valid`=1.
- Between words there is a 2-cycle bubble (READ and WAIT) after the last byte's transfer.
- Minimum duration of an N-word dump with `tx_ready` held high: 1 + N·(2+BYTES) + [1 if CSUM] cycles from start to the DONE cycle.
- `word_count`=0: `done` at cycle 1 and no memory reads.
- Reset asserted mid-operation: immediate return to IDLE. `tx_valid` drops asynchronously and the partial stream is abandoned. No `done` is produced.

## Configuration
- `MEM_DUMP_CHECKSUM_EN` defined:
  - After the final word, state CSUM emits one extra byte equal to the XOR of all streamed data bytes, using the same handshake rules.
  - For `word_count`=0, no checksum byte is sent.
- Undefined: the CSUM state and the XOR accumulator are absent. The stream is exactly N·BYTES bytes.

## Structure
- A shared package `mem_dump_pkg` holds:
  - the state enum.
  - `BYTES` as a function of `DATA_W`.
  - default `ADDR_W`/`DATA_W` constants, shared with `data_mem` depth.
- One sub-module, `word_serializer`: loads a DATA_W word and emits BYTES bytes MSB-first under valid/ready, with a `last` flag. The top FSM owns the addressing and counting.

## Test plan
- Memory[4]=0x00000007, start_addr=4, count=1, `tx_ready`=1 → bytes 00,00,00,07. First `tx_valid` 3 cycles after start. `done` 1 cycle after the 4th transfer.
- Memory[1022]=0x11223344, [1023]=0x55667788, [0]=0xAABBCCDD; start_addr=1022, count=3 → 12 bytes in that order, confirming address wrap.
- Same dump with `tx_ready` toggled pseudo-randomly → identical byte sequence, and `tx_data` never changes while valid and not ready.
- count=0 → `done` at cycle 1, no `mem_rd_en`, no `tx_valid`. A `start` pulsed while busy is ignored.
- Reset pulled low during byte 2 of word 2 → all outputs 0 asynchronously. A fresh start after release dumps correctly from the beginning.
- With `MEM_DUMP_CHECKSUM_EN`: words 0x01020304 and 0x10203040 → 8 data bytes followed by 0x44.
